// File: rtl/simple_axi_slave_mem.sv
// Single-beat AXI4 responder backed by a 64-bit word memory.
// Handles one write or read at a time, with stall, DECERR and SLVERR.
module simple_axi_slave_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 256,
  parameter int          READY_DELAY = 0
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [7:0]  s_axi_awlen,
  input  logic [2:0]  s_axi_awsize,
  input  logic [1:0]  s_axi_awburst,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic [63:0] s_axi_wdata,
  input  logic [7:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [1:0]  s_axi_bresp,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_araddr,
  input  logic [7:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [63:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast,
  output logic        o_busy
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [32:0] SPAN  = 33'(DEPTH) << 3;
  localparam logic [3:0]  RD    = 4'(READY_DELAY);
  localparam logic [1:0]  R_OK  = 2'b00;
  localparam logic [1:0]  R_SLV = 2'b10;
  localparam logic [1:0]  R_DEC = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_W_DATA,
    S_W_RESP,
    S_R_DATA
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [3:0]    cnt;
  logic          cnt_run;
  logic          rdy;
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] w_idx;
  logic [1:0]    w_err;
  logic          w_len0;
  logic          w_end;
  logic          we;
  logic [7:0]    beats;
  logic [31:0]   aw_off;
  logic [31:0]   ar_off;
  logic          aw_hit;
  logic          ar_hit;
  logic [1:0]    aw_resp;
  logic [1:0]    ar_resp;
  logic          unused_ok;

  assign aw_off  = s_axi_awaddr - BASE_ADDR;
  assign ar_off  = s_axi_araddr - BASE_ADDR;
  assign aw_hit  = (s_axi_awaddr >= BASE_ADDR) && ({1'b0, aw_off} < SPAN);
  assign ar_hit  = (s_axi_araddr >= BASE_ADDR) && ({1'b0, ar_off} < SPAN);
  assign aw_resp = !aw_hit ? R_DEC : (s_axi_awlen != 8'd0) ? R_SLV : R_OK;
  assign ar_resp = !ar_hit ? R_DEC : (s_axi_arlen != 8'd0) ? R_SLV : R_OK;
  assign rdy     = (cnt == RD);
  assign w_end   = s_axi_wlast || w_len0;
  assign we      = s_axi_wready && (w_err == R_OK) && s_axi_wlast;

  assign s_axi_bvalid = (state == S_W_RESP);
  assign s_axi_rvalid = (state == S_R_DATA);
  assign o_busy       = (state != S_IDLE);

  assign unused_ok = ^{s_axi_awsize, s_axi_awburst,
                       s_axi_arsize, s_axi_arburst};

  // next state, stall-gated readies and delay counter enable
  always_comb begin
    state_nx      = state;
    s_axi_awready = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_wready  = 1'b0;
    cnt_run       = 1'b0;
    unique case (state)
      S_IDLE: begin
        s_axi_awready = s_axi_awvalid && rdy;
        s_axi_arready = !s_axi_awvalid && s_axi_arvalid && rdy;
        cnt_run       = (s_axi_awvalid || s_axi_arvalid) && !rdy;
        if (s_axi_awready)
          state_nx = S_W_DATA;
        else if (s_axi_arready)
          state_nx = S_R_DATA;
      end
      S_W_DATA: begin
        s_axi_wready = s_axi_wvalid && rdy;
        cnt_run      = s_axi_wvalid && !rdy;
        if (s_axi_wready && w_end)
          state_nx = S_W_RESP;
      end
      S_W_RESP: begin
        if (s_axi_bready)
          state_nx = S_IDLE;
      end
      S_R_DATA: begin
        if (s_axi_rready && s_axi_rlast)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // state, counter, latched decode and response registers
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      w_idx       <= '0;
      w_err       <= R_OK;
      w_len0      <= 1'b0;
      s_axi_bresp <= R_OK;
      s_axi_rresp <= R_OK;
      s_axi_rdata <= 64'd0;
      s_axi_rlast <= 1'b0;
      beats       <= 8'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_run ? cnt + 4'd1 : 4'd0;
      if (s_axi_awready) begin
        w_idx  <= aw_off[AW+2:3];
        w_err  <= aw_resp;
        w_len0 <= (s_axi_awlen == 8'd0);
      end
      if (s_axi_wready && w_end)
        s_axi_bresp <= (w_err == R_OK && !s_axi_wlast) ? R_SLV : w_err;
      if (s_axi_arready) begin
        s_axi_rresp <= ar_resp;
        s_axi_rdata <= (ar_resp == R_OK) ? mem[ar_off[AW+2:3]] : 64'd0;
        s_axi_rlast <= (s_axi_arlen == 8'd0);
        beats       <= s_axi_arlen;
      end else if (s_axi_rvalid && s_axi_rready) begin
        beats       <= beats - 8'd1;
        s_axi_rlast <= (beats == 8'd1);
      end
    end
  end

  // byte-strobed memory write, suppressed in the reset cycle
  always_ff @(posedge i_clk) begin
    if (i_rstn && we) begin
      for (int i = 0; i < 8; i++) begin
        if (s_axi_wstrb[i])
          mem[w_idx][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_simple_axi_slave_mem.sv
// Directed bench for simple_axi_slave_mem.
// Instance 0 has no stall, instance 1 stalls three cycles.
module tb_simple_axi_slave_mem;

  logic clk;
  logic rstn;
  logic awvalid [2];
  logic awready [2];
  logic wvalid  [2];
  logic wready  [2];
  logic wlast   [2];
  logic bvalid  [2];
  logic bready  [2];
  logic arvalid [2];
  logic arready [2];
  logic rvalid  [2];
  logic rready  [2];
  logic rlast   [2];
  logic busy    [2];
  logic [31:0] awaddr [2];
  logic [31:0] araddr [2];
  logic [7:0]  awlen  [2];
  logic [7:0]  arlen  [2];
  logic [63:0] wdata  [2];
  logic [63:0] rdata  [2];
  logic [7:0]  wstrb  [2];
  logic [1:0]  bresp  [2];
  logic [1:0]  rresp  [2];
  logic [2:0]  size3;
  logic [1:0]  incr;
  int total;
  int bad;

  simple_axi_slave_mem #(.READY_DELAY(0)) u0 (
    .i_clk(clk), .i_rstn(rstn),
    .s_axi_awvalid(awvalid[0]), .s_axi_awready(awready[0]),
    .s_axi_awaddr(awaddr[0]), .s_axi_awlen(awlen[0]),
    .s_axi_awsize(size3), .s_axi_awburst(incr),
    .s_axi_wvalid(wvalid[0]), .s_axi_wready(wready[0]),
    .s_axi_wdata(wdata[0]), .s_axi_wstrb(wstrb[0]),
    .s_axi_wlast(wlast[0]),
    .s_axi_bvalid(bvalid[0]), .s_axi_bready(bready[0]),
    .s_axi_bresp(bresp[0]),
    .s_axi_arvalid(arvalid[0]), .s_axi_arready(arready[0]),
    .s_axi_araddr(araddr[0]), .s_axi_arlen(arlen[0]),
    .s_axi_arsize(size3), .s_axi_arburst(incr),
    .s_axi_rvalid(rvalid[0]), .s_axi_rready(rready[0]),
    .s_axi_rdata(rdata[0]), .s_axi_rresp(rresp[0]),
    .s_axi_rlast(rlast[0]), .o_busy(busy[0])
  );

  simple_axi_slave_mem #(.READY_DELAY(3)) u1 (
    .i_clk(clk), .i_rstn(rstn),
    .s_axi_awvalid(awvalid[1]), .s_axi_awready(awready[1]),
    .s_axi_awaddr(awaddr[1]), .s_axi_awlen(awlen[1]),
    .s_axi_awsize(size3), .s_axi_awburst(incr),
    .s_axi_wvalid(wvalid[1]), .s_axi_wready(wready[1]),
    .s_axi_wdata(wdata[1]), .s_axi_wstrb(wstrb[1]),
    .s_axi_wlast(wlast[1]),
    .s_axi_bvalid(bvalid[1]), .s_axi_bready(bready[1]),
    .s_axi_bresp(bresp[1]),
    .s_axi_arvalid(arvalid[1]), .s_axi_arready(arready[1]),
    .s_axi_araddr(araddr[1]), .s_axi_arlen(arlen[1]),
    .s_axi_arsize(size3), .s_axi_arburst(incr),
    .s_axi_rvalid(rvalid[1]), .s_axi_rready(rready[1]),
    .s_axi_rdata(rdata[1]), .s_axi_rresp(rresp[1]),
    .s_axi_rlast(rlast[1]), .o_busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs,
                     input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] outs(input int d);
    return {5'b0, awready[d], wready[d], bvalid[d], arready[d],
            rvalid[d], bresp[d], rresp[d], rlast[d], busy[d], rdata[d]};
  endfunction

  task automatic do_aw(input int d, input logic [31:0] a,
                       input logic [7:0] len, input int exp_wait,
                       input string tag);
    int w;
    w = 0;
    @(posedge clk); #1;
    awaddr[d] = a;
    awlen[d] = len;
    awvalid[d] = 1'b1;
    @(negedge clk);
    while (!awready[d] && w < 40) begin
      w++;
      @(negedge clk);
    end
    chk({tag, "_aw_wait"}, 80'(w), 80'(exp_wait));
    @(posedge clk); #1;
    awvalid[d] = 1'b0;
  endtask

  task automatic do_w(input int d, input logic [63:0] data,
                      input logic [7:0] strb, input logic last,
                      input int exp_wait, input string tag);
    int w;
    w = 0;
    @(posedge clk); #1;
    wdata[d] = data;
    wstrb[d] = strb;
    wlast[d] = last;
    wvalid[d] = 1'b1;
    @(negedge clk);
    while (!wready[d] && w < 40) begin
      w++;
      @(negedge clk);
    end
    chk({tag, "_w_wait"}, 80'(w), 80'(exp_wait));
    @(posedge clk); #1;
    wvalid[d] = 1'b0;
    wlast[d] = 1'b0;
  endtask

  task automatic do_b(input int d, input logic [1:0] exp,
                      input int hold, input string tag);
    int w;
    w = 0;
    @(negedge clk);
    while (!bvalid[d] && w < 40) begin
      w++;
      @(negedge clk);
    end
    chk({tag, "_bresp"}, {77'(bvalid[d]), bresp[d]}, {77'd1, exp});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_bhold"}, {bvalid[d], bresp[d], arready[d]},
          {1'b1, exp, 1'b0});
    end
    bready[d] = 1'b1;
    @(posedge clk); #1;
    bready[d] = 1'b0;
  endtask

  task automatic do_ar(input int d, input logic [31:0] a,
                       input logic [7:0] len, input int exp_wait,
                       input string tag);
    int w;
    w = 0;
    @(posedge clk); #1;
    araddr[d] = a;
    arlen[d] = len;
    arvalid[d] = 1'b1;
    @(negedge clk);
    while (!arready[d] && w < 40) begin
      w++;
      @(negedge clk);
    end
    chk({tag, "_ar_wait"}, 80'(w), 80'(exp_wait));
    @(posedge clk); #1;
    arvalid[d] = 1'b0;
  endtask

  task automatic do_r(input int d, input int n, input logic [63:0] data,
                      input logic [1:0] resp, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_rbeat"},
          {11'd0, rvalid[d], rresp[d], rlast[d], rdata[d]},
          {11'd0, 1'b1, resp, 1'(i == n - 1), data});
      rready[d] = 1'b1;
      @(posedge clk); #1;
      rready[d] = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_idle"}, 80'(busy[d]), 80'd0);
  endtask

  initial begin
    int w;
    total = 0;
    bad = 0;
    size3 = 3'd3;
    incr = 2'd1;
    rstn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      awvalid[d] = 0; wvalid[d] = 0; wlast[d] = 0; bready[d] = 0;
      arvalid[d] = 0; rready[d] = 0;
      awaddr[d] = 0; araddr[d] = 0; awlen[d] = 0; arlen[d] = 0;
      wdata[d] = 0; wstrb[d] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_u0", outs(0), 80'd0);
    chk("reset_u1", outs(1), 80'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    do_aw(0, 32'h0, 8'd0, 0, "w0");
    do_w(0, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1, 0, "w0");
    do_b(0, 2'b00, 0, "w0");

    do_aw(0, 32'h10, 8'd0, 0, "w1");
    do_w(0, 64'h11223344_55667788, 8'hFF, 1'b1, 0, "w1");
    do_b(0, 2'b00, 0, "w1");
    do_ar(0, 32'h10, 8'd0, 0, "r1");
    do_r(0, 1, 64'h11223344_55667788, 2'b00, "r1");

    do_aw(0, 32'h12, 8'd0, 0, "wstb");
    do_w(0, 64'h00000000_AABB0000, 8'h0C, 1'b1, 0, "wstb");
    do_b(0, 2'b00, 0, "wstb");
    do_ar(0, 32'h10, 8'd0, 0, "rstb");
    do_r(0, 1, 64'h11223344_AABB7788, 2'b00, "rstb");

    do_aw(0, 32'h800, 8'd0, 0, "wdec");
    do_w(0, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 1'b1, 0, "wdec");
    do_b(0, 2'b11, 0, "wdec");
    do_ar(0, 32'h0, 8'd0, 0, "rw0");
    do_r(0, 1, 64'hDEADBEEF_CAFEF00D, 2'b00, "rw0");
    do_ar(0, 32'h800, 8'd0, 0, "rdec");
    do_r(0, 1, 64'd0, 2'b11, "rdec");

    do_ar(0, 32'h10, 8'd3, 0, "rbst");
    do_r(0, 4, 64'd0, 2'b10, "rbst");

    do_aw(0, 32'h10, 8'd1, 0, "wbst");
    do_w(0, 64'h0, 8'hFF, 1'b0, 0, "wbst0");
    do_w(0, 64'h0, 8'hFF, 1'b1, 0, "wbst1");
    do_b(0, 2'b10, 0, "wbst");
    do_ar(0, 32'h10, 8'd0, 0, "rbw");
    do_r(0, 1, 64'h11223344_AABB7788, 2'b00, "rbw");

    @(posedge clk); #1;
    awaddr[1] = 32'h20;
    awlen[1] = 8'd0;
    araddr[1] = 32'h20;
    arlen[1] = 8'd0;
    awvalid[1] = 1'b1;
    arvalid[1] = 1'b1;
    w = 0;
    @(negedge clk);
    while (!awready[1] && w < 40) begin
      w++;
      @(negedge clk);
    end
    chk("prio_aw_wait", 80'(w), 80'd3);
    chk("prio_ar_low", 80'(arready[1]), 80'd0);
    @(posedge clk); #1;
    awvalid[1] = 1'b0;
    do_w(1, 64'h01234567_89ABCDEF, 8'hFF, 1'b1, 3, "stall");
    do_b(1, 2'b00, 5, "stall");
    w = 0;
    @(negedge clk);
    while (!arready[1] && w < 40) begin
      w++;
      @(negedge clk);
    end
    chk("prio_ar_wait", 80'(w), 80'd3);
    @(posedge clk); #1;
    arvalid[1] = 1'b0;
    do_r(1, 1, 64'h01234567_89ABCDEF, 2'b00, "stall");

    do_aw(0, 32'h18, 8'd0, 0, "wpre");
    do_w(0, 64'h5555AAAA_5555AAAA, 8'hFF, 1'b1, 0, "wpre");
    do_b(0, 2'b00, 0, "wpre");
    do_aw(0, 32'h18, 8'd0, 0, "wrst");
    @(posedge clk); #1;
    wdata[0] = 64'hFFFFFFFF_FFFFFFFF;
    wstrb[0] = 8'hFF;
    wlast[0] = 1'b1;
    wvalid[0] = 1'b1;
    rstn = 1'b0;
    @(posedge clk); #1;
    wvalid[0] = 1'b0;
    wlast[0] = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_u0", outs(0), 80'd0);
    chk("midrst_u1", outs(1), 80'd0);
    do_ar(0, 32'h18, 8'd0, 0, "rrst");
    do_r(0, 1, 64'h5555AAAA_5555AAAA, 2'b00, "rrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simple_axi_slave_mem.md
Name: simple_axi_slave_mem

Overview:
- AXI4 responder for the 64-bit single-beat AXI master traffic, backed by an internal 64-bit word memory.
- Serves one transaction at a time: write or read, never both.
- Used as the bench and SoC target for master-side logic.
- Provides programmable handshake stall, address decoding (DECERR) and burst rejection (SLVERR), so every master response path can be exercised.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 8-byte aligned.
- DEPTH, 256, number of 64-bit words; power of two, ≥2.
- READY_DELAY, 0, idle cycles a valid is held before awready/arready/wready is asserted; 0..15.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  synchronous active-low reset
- s_axi_awvalid in 1, s_axi_awready out 1, s_axi_awaddr in 32, s_axi_awlen in 8, s_axi_awsize in 3, s_axi_awburst in 2  write address channel (cache/prot/lock/qos not connected)
- s_axi_wvalid in 1, s_axi_wready out 1, s_axi_wdata in 64, s_axi_wstrb in 8, s_axi_wlast in 1  write data channel
- s_axi_bvalid out 1, s_axi_bready in 1, s_axi_bresp out 2  write response channel
- s_axi_arvalid in 1, s_axi_arready out 1, s_axi_araddr in 32, s_axi_arlen in 8, s_axi_arsize in 3, s_axi_arburst in 2  read address channel
- s_axi_rvalid out 1, s_axi_rready in 1, s_axi_rdata out 64, s_axi_rresp out 2, s_axi_rlast out 1  read data channel
- o_busy  out  1  high in any state other than S_IDLE

Behaviour:
- Clock i_clk. Reset i_rstn is synchronous and active-low.
- Reset: state S_IDLE, delay counter 0. All ready/valid outputs 0; bresp, rresp, rdata = 0; rlast = 0; o_busy = 0. Memory contents are not reset.
- Reset mid-transaction: abandon the transaction; no partial write is performed after the reset edge.
- Decode: hit when BASE_ADDR ≤ addr < BASE_ADDR + DEPTH*8. Word index = (addr - BASE_ADDR) >> 3. Address bits [2:0] are ignored; wstrb selects bytes; rdata returns the full 64-bit word.
- Error priority: miss → DECERR (2'b11); else len ≠ 0 → SLVERR (2'b10); else OKAY (2'b00).
- Delay counter:
  - Counts while the relevant valid is high and ready is low, in S_IDLE or S_W_DATA.
  - Ready asserts combinationally when count == READY_DELAY, for one cycle or until the handshake completes.
  - Counter clears on each handshake and on leaving the state.
- S_IDLE:
  - awvalid has priority over arvalid when both are high.
  - AW handshake: latch decode result and len; go to S_W_DATA.
  - AR handshake: latch index, response and beat count = arlen+1; go to S_R_DATA.
- S_W_DATA:
  - wready follows the delay rule; each W handshake consumes one beat.
  - OKAY and beat 0: memory bytes with wstrb[i] = 1 are written at that clock edge; other bytes keep their value.
  - Error cases: beats are consumed without writing.
  - Transaction ends at wlast = 1. If len = 0 and wlast = 0, the beat is still treated as last and the response is SLVERR.
  - Go to S_W_RESP.
- S_W_RESP: bvalid = 1 with latched bresp; hold until bready. On the handshake return to S_IDLE; next AW is acceptable the following cycle at the earliest.
- S_R_DATA:
  - rvalid = 1 from the first cycle in state; read latency after the AR handshake is 1 cycle.
  - rdata = mem[index] for OKAY, 0 for errors; rresp latched.
  - rlast = 1 on the final beat.
  - rdata, rresp and rlast stay stable while rvalid && !rready.
  - Each R handshake decrements the beat count; the handshake with rlast returns to S_IDLE.
  - Error bursts return arlen+1 beats, all carrying the error.
- The slave never asserts awready and arready in the same cycle.
- W beats arriving before AW are not accepted: wready = 0 outside S_W_DATA.
- A write then read to the same address in back-to-back transactions returns the new data.
- All outputs are registered or decoded from registered state; no combinational valid→valid path. The ready→delay path is allowed.

Test Plan:
- Write OKAY: READY_DELAY=0, AW addr 0x10, wdata 0x1122334455667788, wstrb 0xFF → awready same cycle, bresp 00. Then AR 0x10 → rdata 0x1122334455667788, rresp 00, rlast 1, rvalid one cycle after the AR handshake.
- Strobed write: prior word 0x1122334455667788; write addr 0x12, wdata 0xAABB<<16, wstrb 0x0C → read of 0x10 returns 0x11223344AABB7788.
- Decode error: write 0x800 with DEPTH=256 → bresp 11, memory unchanged. Read of 0x800 → rresp 11, rdata 0.
- Burst reject: arlen=3 → four R beats with rresp 10, rlast only on the 4th. awlen=1 with two W beats → bresp 10, memory unchanged.
- Stall and priority: READY_DELAY=3, awvalid and arvalid asserted together → awready after 3 cycles, arready only after the B handshake. bready held low 5 cycles → bvalid and bresp stable throughout.
- Reset mid-transaction: i_rstn low for one cycle during S_W_DATA → all outputs 0, o_busy 0 next cycle, target word unchanged.
